// File: rtl/fast_inv_sqrt_wb_pkg.sv
// Shared definitions for the queued inverse-square-root Wishbone peripheral:
// register map, STATUS/CTRL bit positions and FSM state encodings.
package fast_inv_sqrt_wb_pkg;

    // Word offsets decoded from adr_i[3:2]
    localparam logic [1:0] REG_DATA_IN  = 2'd0;
    localparam logic [1:0] REG_DATA_OUT = 2'd1;
    localparam logic [1:0] REG_STATUS   = 2'd2;
    localparam logic [1:0] REG_CTRL     = 2'd3;

    // STATUS bit positions (in_count sits at bit 0)
    localparam int ST_OUT_LSB = 8;
    localparam int ST_BUSY    = 16;
    localparam int ST_OVF     = 17;
    localparam int ST_UNF     = 18;

    // CTRL bit positions
    localparam int CTRL_IRQ_EN  = 0;
    localparam int CTRL_CLR_OVF = 1;
    localparam int CTRL_CLR_UNF = 2;
    localparam int CTRL_FLUSH   = 3;

    // Dispatcher moving operands from the input FIFO through the core
    typedef enum logic [1:0] {
        D_IDLE  = 2'd0,
        D_ISSUE = 2'd1,
        D_WAIT  = 2'd2,
        D_STORE = 2'd3
    } disp_state_e;

    // Core sequencer
    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_CALC = 2'd1,
        C_DONE = 2'd2
    } core_state_e;

endpackage

// File: rtl/fast_inv_sqrt.sv
// Fixed-point 1/sqrt(x) core. Finds the largest r with r*r*x <= 2^(3*F),
// i.e. floor(1/sqrt(x)) in the same Q format, one result bit per cycle.
// x = 0 saturates to all ones. valid/ready: a transfer happens on a cycle
// where both valid and ready are high at the rising edge.
module fast_inv_sqrt
    import fast_inv_sqrt_wb_pkg::*;
#(
    parameter int INT_WIDTH   = 12,
    parameter int FRACT_WIDTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [INT_WIDTH+FRACT_WIDTH-1:0] data_in,
    input  logic                             valid_in,
    output logic                             ready_in,
    output logic [INT_WIDTH+FRACT_WIDTH-1:0] data_out,
    output logic                             valid_out,
    input  logic                             ready_out
);
    localparam int DW = INT_WIDTH + FRACT_WIDTH;
    localparam int PW = 3 * DW;
    localparam logic [PW-1:0] LIMIT = PW'(1) << (3 * FRACT_WIDTH);

    core_state_e   state_q, state_d;
    logic [DW-1:0] x_q, x_d, r_q, r_d, mask_q, mask_d, trial;
    logic [PW-1:0] prod;

    // Bit-serial search from the MSB down, plus handshake outputs
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        r_d       = r_q;
        mask_d    = mask_q;
        ready_in  = 1'b0;
        valid_out = 1'b0;
        trial     = r_q | mask_q;
        prod      = PW'(trial) * PW'(trial) * PW'(x_q);
        case (state_q)
            C_IDLE: begin
                ready_in = 1'b1;
                if (valid_in) begin
                    x_d     = data_in;
                    r_d     = '0;
                    mask_d  = DW'(1) << (DW - 1);
                    state_d = C_CALC;
                end
            end
            C_CALC: begin
                if (prod <= LIMIT) begin
                    r_d = trial;
                end
                mask_d = mask_q >> 1;
                if (mask_q[0]) begin
                    state_d = C_DONE;
                end
            end
            C_DONE: begin
                valid_out = 1'b1;
                if (ready_out) begin
                    state_d = C_IDLE;
                end
            end
            default: state_d = C_IDLE;
        endcase
    end

    // Core state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= C_IDLE;
            x_q     <= '0;
            r_q     <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            r_q     <= r_d;
            mask_q  <= mask_d;
        end
    end

    assign data_out = r_q;

endmodule

// File: rtl/isqrt_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; dout always shows the head entry.
// flush empties the FIFO and overrides any same-cycle push or pop.
module isqrt_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    // Accept pushes only with space, pops only with data; pointers wrap naturally
    always_comb begin
        push_ok  = push & ~full & ~flush;
        pop_ok   = pop & ~empty & ~flush;
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful below count so no reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/fast_inv_sqrt_wb_queue.sv
// Wishbone slave around the inverse-sqrt core: input FIFO -> dispatcher ->
// core -> output FIFO, with STATUS/CTRL registers, sticky OVF/UNF flags and a
// maskable level interrupt. Bus side effects occur once, in the ack cycle.
// Dispatcher state is visible to software as STATUS.busy.
module fast_inv_sqrt_wb_queue
    import fast_inv_sqrt_wb_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        we_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    output logic        ack_o,
    output logic        interrupt
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                  ack_q, ack_d, irq_q, irq_d;
    logic                  irq_en_q, irq_en_d, ovf_q, ovf_d, unf_q, unf_d;
    logic                  core_rst_q, core_rst_d;
    disp_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;

    logic                  bus_valid, bus_wr, bus_rd, ctrl_wr, flush;
    logic [1:0]            reg_sel;
    logic                  in_push, in_pop, in_full, in_empty;
    logic                  out_push, out_pop, out_full, out_empty;
    logic [CW-1:0]         in_count, out_count;
    logic [DATA_WIDTH-1:0] in_head, out_head, core_dout;
    logic                  core_valid_in, core_ready_in, core_valid_out, core_ready_out;
    logic [31:0]           status, rd_data;
    logic                  unused_bits;

    assign unused_bits = ^{adr_i[31:4], adr_i[1:0], dat_i[31:DATA_WIDTH], out_full};

    // Bus decode: ack one cycle after a request, act only in the ack cycle
    always_comb begin
        bus_valid = cyc_i & stb_i;
        ack_d     = bus_valid & ~ack_q;
        bus_wr    = bus_valid & ack_q & we_i;
        bus_rd    = bus_valid & ack_q & ~we_i;
        reg_sel   = adr_i[3:2];
        ctrl_wr   = bus_wr & (reg_sel == REG_CTRL);
        flush     = ctrl_wr & dat_i[CTRL_FLUSH];
        in_push   = bus_wr & (reg_sel == REG_DATA_IN) & ~in_full;
        out_pop   = bus_rd & (reg_sel == REG_DATA_OUT) & ~out_empty;
        ovf_d     = (ovf_q & ~(ctrl_wr & dat_i[CTRL_CLR_OVF]))
                  | (bus_wr & (reg_sel == REG_DATA_IN) & in_full);
        unf_d     = (unf_q & ~(ctrl_wr & dat_i[CTRL_CLR_UNF]))
                  | (bus_rd & (reg_sel == REG_DATA_OUT) & out_empty);
        irq_en_d  = ctrl_wr ? dat_i[CTRL_IRQ_EN] : irq_en_q;
        core_rst_d = flush;
        irq_d     = irq_en_q & ((out_count != '0) | ovf_q | unf_q);
    end

    // Dispatcher: one operation in flight, output slot reserved before issue
    always_comb begin
        state_d        = state_q;
        result_d       = result_q;
        core_valid_in  = 1'b0;
        core_ready_out = 1'b0;
        in_pop         = 1'b0;
        out_push       = 1'b0;
        case (state_q)
            D_IDLE: begin
                if (~in_empty && (out_count < CW'(FIFO_DEPTH))) begin
                    state_d = D_ISSUE;
                end
            end
            D_ISSUE: begin
                core_valid_in = ~core_rst_q;
                if (core_valid_in & core_ready_in) begin
                    in_pop  = 1'b1;
                    state_d = D_WAIT;
                end
            end
            D_WAIT: begin
                core_ready_out = 1'b1;
                if (core_valid_out) begin
                    result_d = core_dout;
                    state_d  = D_STORE;
                end
            end
            D_STORE: begin
                out_push = 1'b1;
                state_d  = D_IDLE;
            end
            default: state_d = D_IDLE;
        endcase
        if (flush) begin
            state_d = D_IDLE;
        end
    end

    // Register read mux; DATA_OUT reads empty as zero
    always_comb begin
        status                         = '0;
        status[CW-1:0]                 = in_count;
        status[ST_OUT_LSB +: CW]       = out_count;
        status[ST_BUSY]                = (state_q != D_IDLE);
        status[ST_OVF]                 = ovf_q;
        status[ST_UNF]                 = unf_q;
        rd_data = '0;
        case (reg_sel)
            REG_DATA_OUT: rd_data = out_empty ? 32'd0 : 32'(out_head);
            REG_STATUS:   rd_data = status;
            REG_CTRL:     rd_data = {31'd0, irq_en_q};
            default:      rd_data = '0;
        endcase
    end

    // Control, flag, dispatcher and core-reset registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q      <= 1'b0;
            irq_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            core_rst_q <= 1'b1;
            state_q    <= D_IDLE;
            result_q   <= '0;
        end else begin
            ack_q      <= ack_d;
            irq_q      <= irq_d;
            irq_en_q   <= irq_en_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            core_rst_q <= core_rst_d;
            state_q    <= state_d;
            result_q   <= result_d;
        end
    end

    assign ack_o     = ack_q;
    assign dat_o     = (ack_q & ~we_i) ? rd_data : 32'd0;
    assign interrupt = irq_q;

    isqrt_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_in_fifo (
        .clk(clk), .rst(rst), .flush(flush),
        .push(in_push), .din(dat_i[DATA_WIDTH-1:0]),
        .pop(in_pop), .dout(in_head),
        .full(in_full), .empty(in_empty), .count(in_count)
    );

    isqrt_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_out_fifo (
        .clk(clk), .rst(rst), .flush(flush),
        .push(out_push), .din(result_q),
        .pop(out_pop), .dout(out_head),
        .full(out_full), .empty(out_empty), .count(out_count)
    );

    fast_inv_sqrt #(
        .INT_WIDTH(DATA_WIDTH - FRACT_WIDTH),
        .FRACT_WIDTH(FRACT_WIDTH)
    ) u_core (
        .clk(clk), .rst(rst | core_rst_q),
        .data_in(in_head), .valid_in(core_valid_in), .ready_in(core_ready_in),
        .data_out(core_dout), .valid_out(core_valid_out), .ready_out(core_ready_out)
    );

endmodule

// File: tb/tb_fast_inv_sqrt_wb_queue.sv
// Directed bench for fast_inv_sqrt_wb_queue (DATA_WIDTH=16, FRACT_WIDTH=4,
// FIFO_DEPTH=4). Bus transfers: request driven on a falling edge, ack seen
// one rising edge later, request dropped on the falling edge after the
// side-effect edge. All outputs sampled on falling edges.
module tb_fast_inv_sqrt_wb_queue;
    localparam int DW = 16;
    localparam int FW = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr_i, dat_i, dat_o;
    logic        we_i, stb_i, cyc_i, ack_o, interrupt;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] rdata;
    logic [15:0] exp_res [4];

    always #5 clk = ~clk;

    fast_inv_sqrt_wb_queue #(.DATA_WIDTH(DW), .FRACT_WIDTH(FW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
        .we_i(we_i), .stb_i(stb_i), .cyc_i(cyc_i), .ack_o(ack_o), .interrupt(interrupt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Result within +/-1 LSB of the hand-computed value
    task automatic check_near(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        longint diff;
        diff = longint'(obs) - longint'(exp);
        tests_run++;
        assert (!$isunknown(obs) && diff >= -1 && diff <= 1) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h +/-1", tag, obs, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rd);
        int n;
        @(negedge clk);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we;
        adr_i = {28'd0, addr}; dat_i = wdata;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack_o && n < 8);
        rd = dat_o;
        if (!ack_o) begin
            tests_run++;
            tests_failed++;
            $error("FAIL ack_timeout: observed no ack at addr 0x%0h expected ack", addr);
        end
        @(negedge clk);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic wb_write(input logic [3:0] addr, input logic [31:0] wdata);
        logic [31:0] dummy;
        wb_xfer(1'b1, addr, wdata, dummy);
    endtask

    task automatic wb_read(input logic [3:0] addr, output logic [31:0] rd);
        wb_xfer(1'b0, addr, 32'd0, rd);
    endtask

    // Poll STATUS until out_count reaches n (bounded)
    task automatic wait_out_count(input int n, input string tag);
        int k;
        logic [31:0] s;
        k = 0;
        do begin
            wb_read(4'h8, s);
            k++;
        end while (s[10:8] != 3'(n) && k < 100);
        check(tag, {29'd0, s[10:8]}, 32'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; adr_i = '0; dat_i = '0; we_i = 1'b0; stb_i = 1'b0; cyc_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_ack", {31'd0, ack_o}, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_irq", {31'd0, interrupt}, 32'd0);
        wb_read(4'h8, rdata);
        check("rst_status", rdata, 32'd0);

        // Single operation: 4.0 -> 0.5
        wb_write(4'h0, 32'h0040);
        wait_out_count(1, "t1_wait");
        wb_read(4'h4, rdata);
        check_near("t1_result", rdata, 32'h0008);
        wb_read(4'h8, rdata);
        check("t1_status", rdata, 32'd0);

        // Four back-to-back operands, results in order
        exp_res[0] = 16'h0008; exp_res[1] = 16'h0004; exp_res[2] = 16'h0010; exp_res[3] = 16'h0003;
        wb_write(4'h0, 32'h0040);
        wb_write(4'h0, 32'h0100);
        wb_write(4'h0, 32'h0010);
        wb_write(4'h0, 32'h0190);
        wait_out_count(4, "t2_wait");
        wb_read(4'h8, rdata);
        check("t2_status_full_no_ovf", rdata, 32'h0000_0400);
        for (int i = 0; i < 4; i++) begin
            wb_read(4'h4, rdata);
            check_near($sformatf("t2_result%0d", i), rdata, 32'(exp_res[i]));
        end

        // Overflow with the output FIFO full and unread
        for (int i = 0; i < DEPTH; i++) wb_write(4'h0, 32'h0040);
        wait_out_count(4, "t3_wait");
        for (int i = 0; i < DEPTH + 1; i++) wb_write(4'h0, 32'h0010);
        wb_read(4'h8, rdata);
        check("t3_status_ovf", rdata, 32'h0002_0404);
        wb_write(4'hC, 32'h2);
        wb_read(4'h8, rdata);
        check("t3_status_ovf_clr", rdata, 32'h0000_0404);
        wb_write(4'hC, 32'h8);
        wb_read(4'h8, rdata);
        check("t3_status_flushed", rdata, 32'd0);

        // Underflow and interrupt latency
        wb_read(4'h4, rdata);
        check("t4_empty_read", rdata, 32'd0);
        wb_read(4'h8, rdata);
        check("t4_status_unf", rdata, 32'h0004_0000);
        wb_write(4'hC, 32'h1);
        check("t4_irq_latency", {31'd0, interrupt}, 32'd0);
        @(negedge clk);
        check("t4_irq_unf", {31'd0, interrupt}, 32'd1);
        wb_write(4'hC, 32'h5);
        check("t4_irq_hold", {31'd0, interrupt}, 32'd1);
        @(negedge clk);
        check("t4_irq_clr", {31'd0, interrupt}, 32'd0);

        // Interrupt from a ready result
        wb_write(4'h0, 32'h0040);
        for (int i = 0; i < 60 && !interrupt; i++) @(negedge clk);
        check("t5_irq_rise", {31'd0, interrupt}, 32'd1);
        wb_read(4'h8, rdata);
        check("t5_status", rdata, 32'h0000_0100);
        wb_read(4'h4, rdata);
        check_near("t5_result", rdata, 32'h0008);
        check("t5_irq_still", {31'd0, interrupt}, 32'd1);
        @(negedge clk);
        check("t5_irq_fall", {31'd0, interrupt}, 32'd0);
        wb_write(4'hC, 32'h0);

        // Soft flush while an operation is in flight
        wb_write(4'h0, 32'h0040);
        wb_write(4'h0, 32'h0100);
        wb_write(4'h0, 32'h0010);
        wb_read(4'h8, rdata);
        check("t6_status_busy", rdata, 32'h0001_0002);
        wb_write(4'hC, 32'h8);
        wb_read(4'h8, rdata);
        check("t6_status_flushed", rdata, 32'd0);
        wb_write(4'h0, 32'h0040);
        wait_out_count(1, "t6_wait");
        wb_read(4'h4, rdata);
        check_near("t6_result", rdata, 32'h0008);

        // Reset in the middle of an operation
        wb_write(4'hC, 32'h1);
        wb_write(4'h0, 32'h0040);
        wb_write(4'h0, 32'h0040);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t7_ack", {31'd0, ack_o}, 32'd0);
        check("t7_dat", dat_o, 32'd0);
        check("t7_irq", {31'd0, interrupt}, 32'd0);
        wb_read(4'h8, rdata);
        check("t7_status", rdata, 32'd0);
        wb_read(4'hC, rdata);
        check("t7_ctrl", rdata, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
